// File: rtl/tdm_demux.sv
//------------------------------------------------------------------------------
// Module      : tdm_demux
// Description : Time-division demultiplexer; rebuilds the parallel lane word
//               from a framed serial sample stream.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tdm_demux #(
  parameter int LANES = 2,
  parameter int WIDTH = 1,
  parameter int SEL_W = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in,
  input  logic                   in_valid,
  input  logic                   frame_start,
  output logic [LANES*WIDTH-1:0] out,
  output logic                   out_valid,
  output logic [SEL_W-1:0]       sel,
  output logic                   sync_err
);

  localparam logic [SEL_W-1:0] c_LAST = SEL_W'(LANES - 1);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SEL_W-1:0]       r_sel;
  logic [SEL_W-1:0]       w_sel_nxt;
  logic [LANES*WIDTH-1:0] r_shadow;
  logic [LANES*WIDTH-1:0] w_shadow_nxt;
  logic [LANES*WIDTH-1:0] r_out;
  logic [LANES*WIDTH-1:0] w_out_nxt;
  logic                   r_out_valid;
  logic                   w_out_valid_nxt;
  logic                   r_sync_err;
  logic                   w_sync_err_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_shadow    <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_shadow    <= w_shadow_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_sync_err  <= w_sync_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sel_nxt       = r_sel;
    w_shadow_nxt    = r_shadow;
    w_out_nxt       = r_out;
    w_out_valid_nxt = 1'b0;
    w_sync_err_nxt  = 1'b0;

    if (in_valid) begin
      case (r_state)
        S_IDLE: begin
          // Unframed samples are silently dropped until a frame start appears.
          if (frame_start) begin
            w_shadow_nxt[WIDTH-1:0] = in;
            w_sel_nxt               = SEL_W'(1);
            w_state_nxt             = S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (frame_start) begin
            // Resync: upper shadow lanes stay stale but are refilled before use.
            w_sync_err_nxt          = 1'b1;
            w_shadow_nxt[WIDTH-1:0] = in;
            w_sel_nxt               = SEL_W'(1);
          end else if (r_sel == c_LAST) begin
            w_out_nxt                               = r_shadow;
            w_out_nxt[(LANES-1)*WIDTH +: WIDTH]     = in;
            w_out_valid_nxt                         = 1'b1;
            w_sel_nxt                               = '0;
            w_state_nxt                             = S_IDLE;
          end else begin
            for (int k = 0; k < LANES; k++) begin
              if (r_sel == SEL_W'(k)) begin
                w_shadow_nxt[k*WIDTH +: WIDTH] = in;
              end
            end
            w_sel_nxt = r_sel + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign sel       = r_sel;
  assign sync_err  = r_sync_err;

endmodule

`default_nettype wire

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: the receive end of the 2:1/N:1 mux path.
- A mux scanning its select walks lanes onto one serial stream. This block watches that stream, steers each sample back into its lane register, and presents the rebuilt parallel word.
- The rebuilt word uses the same bit ordering as the mux input bus: lane 0 in the LSBs, slot k to lane k. A mux-then-demux round trip is therefore bit-identical.

Parameters:
- LANES, 2, number of time slots per frame (min 2).
- WIDTH, 1, bits per lane sample.
- SEL_W, 1, width of slot index; LANES must be no greater than 2^SEL_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in  input  WIDTH  serial sample from upstream mux.
- in_valid  input  1  sample on `in` is valid this cycle.
- frame_start  input  1  qualifies the current valid sample as slot 0.
- out  output  LANES*WIDTH  rebuilt parallel word; lane k at bits [k*WIDTH +: WIDTH].
- out_valid  output  1  one-cycle pulse: `out` just updated with a complete frame.
- sel  output  SEL_W  slot index expected for the next accepted sample.
- sync_err  output  1  one-cycle pulse: frame_start arrived mid-frame.

Behaviour:
- Reset (async, any time, including mid-frame):
  - out=0, out_valid=0, sel=0, sync_err=0, shadow buffer=0, state=IDLE.
  - The partial frame is discarded.
- Accepted sample: in_valid=1 at a rising clk. frame_start is ignored when in_valid=0.
- State IDLE:
  - in_valid & frame_start: store `in` to shadow lane 0, sel<=1, go to COLLECT.
  - in_valid & !frame_start: sample dropped, no error, sel stays 0.
- State COLLECT:
  - in_valid & !frame_start & sel<LANES-1: store `in` to shadow lane[sel], sel<=sel+1.
  - in_valid & !frame_start & sel==LANES-1 (last slot): on the same edge, `out` <= shadow with the last lane replaced by `in`; out_valid<=1 for one cycle; sel<=0; go to IDLE.
  - in_valid & frame_start (resync): sync_err<=1 for one cycle; the partial frame is abandoned and no out_valid is produced. The current sample goes to lane 0, sel<=1, stay in COLLECT. Shadow lanes above 0 keep stale data but are always rewritten before the next completion.
  - !in_valid: hold; bubbles of any length are allowed between slots.
- Latency: out/out_valid change on the clock edge that accepts the last slot, i.e. they are visible in the cycle after the last slot is presented.
- `out` holds its value between completions. Lanes in `out` never update individually; only a whole-frame update is allowed.
- Back-to-back frames: frame_start on the cycle right after a completion is accepted normally (from IDLE). Throughput is one frame per LANES valid cycles.
- sel wrap: never exceeds LANES-1. It returns to 0 only on completion or reset; on resync it goes to 1.
- out_valid and sync_err are never high in the same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset:
  - Drive frame 0, 1. Assert reset mid-clock (between edges) after the first sample.
  - Required: out=0, sel=0 immediately, with no clk edge needed.
  - Then frame 1, 1: out=2'b11, one out_valid pulse.
- Round trip (LANES=2, WIDTH=1): for each in pair (0,0), (1,0), (0,1), (1,1) as slot0, slot1 with frame_start on slot0:
  - out = 2'b00, 2'b01, 2'b10, 2'b11 respectively.
  - One out_valid pulse per frame, the cycle after slot1.
- Bubbles: slot0=1, three cycles of in_valid=0, slot1=0.
  - sel=1 throughout the gap.
  - out=2'b01 only after slot1; out_valid count=1.
- Resync: slot0=1, then frame_start with in=0, then slot1=1.
  - sync_err pulses exactly once, with no out_valid for the aborted frame.
  - Final out=2'b10.
- Unframed data: in_valid=1 with frame_start=0 for 5 cycles from IDLE.
  - out unchanged, out_valid=0, sync_err=0, sel=0.
- Back-to-back (LANES=4, WIDTH=8): frames {A0,A1,A2,A3} then {B0,B1,B2,B3}, no gaps.
  - out=32'hA3A2A1A0, then out=32'hB3B2B1B0, on consecutive completions 4 cycles apart.
